llc_core_arbiter: RTL and testbench

- Shares the single LLC/main-memory port between NUM_CORES cores; each core presents its own LLC request port (req/we/addr/data/req_reset).
- Fair round-robin grant; one transaction outstanding at a time.
- Captures the memory response and returns it only to the owning core.
- Sits between the core array and the LLC in the multi-core top level.

---
 rtl/llc_core_arbiter_pkg.sv | 15 +
 rtl/llc_core_arbiter_rr_pick.sv | 30 +++
 rtl/llc_core_arbiter.sv | 112 +++++++++++
 tb/tb_llc_core_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/llc_core_arbiter_pkg.sv
// rtl/llc_core_arbiter_pkg.sv - shared state encodings and LLC widths for the core arbiter
package llc_core_arbiter_pkg;

  localparam int LLC_ADDR_W = 20;
  localparam int LLC_DATA_W = 128;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP,
    ARB_HOLD
  } arb_state_t;

endpackage

// File: rtl/llc_core_arbiter_rr_pick.sv
// rtl/llc_core_arbiter_rr_pick.sv - combinational round-robin pick starting at rr_ptr with wrap
module rr_priority_pick
  import llc_core_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest eligible index wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(rr_ptr) + off) % N);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/llc_core_arbiter.sv
// rtl/llc_core_arbiter.sv - round-robin arbiter sharing one LLC port between NUM_CORES cores
module llc_core_arbiter
  import llc_core_arbiter_pkg::*;
#(
  parameter  int NUM_CORES = 2,
  parameter  int ADDR_W    = LLC_ADDR_W,
  parameter  int DATA_W    = LLC_DATA_W,
  localparam int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_req_reset,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [NUM_CORES-1:0]        core_ready,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready,
  output logic [IDX_W-1:0]            owner,
  output logic                        busy
);

  arb_state_t           state, state_nxt;
  logic [NUM_CORES-1:0] eligible;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     rr_ptr;
  logic                 drop_q;
  logic                 cancel_now;

  assign eligible   = core_req & ~core_req_reset;
  assign cancel_now = core_req_reset[owner];
  assign busy       = (state != ARB_IDLE);

  rr_priority_pick #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_pick (
    .req         (eligible),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (grant_valid) state_nxt = ARB_ISSUE;
      ARB_ISSUE: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (mem_ready) state_nxt = ARB_RESP;
      ARB_RESP:  state_nxt = ARB_HOLD;
      ARB_HOLD:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= '0;
      rr_ptr     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
      core_ready <= '0;
      drop_q     <= 1'b0;
    end else begin
      core_ready <= '0;
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            owner     <= grant_idx;
            mem_req   <= 1'b1;
            mem_we    <= core_we[grant_idx];
            mem_addr  <= core_addr[grant_idx*ADDR_W +: ADDR_W];
            mem_wdata <= core_wdata[grant_idx*DATA_W +: DATA_W];
            drop_q    <= 1'b0;
          end
        end
        ARB_ISSUE: drop_q <= drop_q | cancel_now;
        ARB_WAIT: begin
          drop_q <= drop_q | cancel_now;
          // The LLC cannot abort, so a cancelled transaction still runs to mem_ready
          // and only its response is discarded.
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!(drop_q || cancel_now)) begin
              core_rdata        <= mem_rdata;
              core_ready[owner] <= 1'b1;
            end
          end
        end
        ARB_RESP: rr_ptr <= (owner == IDX_W'(NUM_CORES - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_llc_core_arbiter.sv
// tb/tb_llc_core_arbiter.sv - scoreboard bench for the LLC core arbiter with a 4-core configuration
module tb_llc_core_arbiter;

  localparam int NC = 4;
  localparam int AW = 20;
  localparam int DW = 128;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NC-1:0]  core_req, core_we, core_req_reset;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_wdata;
  logic [DW-1:0]  core_rdata;
  logic [NC-1:0]  core_ready;
  logic           mem_req, mem_we, mem_ready;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata, mem_rdata;
  logic [IW-1:0]  owner;
  logic           busy;

  always #5 clk = ~clk;

  llc_core_arbiter #(
    .NUM_CORES (NC),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .core_req       (core_req),
    .core_we        (core_we),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_req_reset (core_req_reset),
    .core_rdata     (core_rdata),
    .core_ready     (core_ready),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .owner          (owner),
    .busy           (busy)
  );

  typedef struct {
    int            core;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            keep;
    int            cancel_at;
  } sb_item_t;

  sb_item_t      sb[$];
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] last_rdata;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mem_req"}, mem_req, 1'b0);
    check({pfx, "_mem_we"}, mem_we, 1'b0);
    check({pfx, "_mem_addr"}, mem_addr, '0);
    check({pfx, "_mem_wdata"}, mem_wdata, '0);
    check({pfx, "_core_rdata"}, core_rdata, '0);
    check({pfx, "_core_ready"}, core_ready, '0);
    check({pfx, "_owner"}, owner, '0);
    check({pfx, "_busy"}, busy, 1'b0);
  endtask

  task automatic drive_core(input int c, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    core_req[c]            = 1'b1;
    core_we[c]             = we;
    core_addr[c*AW +: AW]  = addr;
    core_wdata[c*DW +: DW] = wdata;
  endtask

  task automatic post(input int c, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] rdata, input bit keep, input int cancel_at);
    sb_item_t it;
    drive_core(c, we, addr, wdata);
    it.core = c; it.we = we; it.addr = addr; it.wdata = wdata;
    it.rdata = rdata; it.keep = keep; it.cancel_at = cancel_at;
    sb.push_back(it);
  endtask

  task automatic wait_issue(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (mem_req !== 1'b1 && waited < 20);
    check("issue_seen", mem_req, 1'b1);
  endtask

  // Acts as the LLC for the oldest expected transaction and checks the response path.
  task automatic serve(input int exp_wait, input int lat);
    sb_item_t      it;
    int            waited;
    logic [NC-1:0] exp_ready;
    logic [DW-1:0] exp_rdata;
    it = sb.pop_front();
    wait_issue(waited);
    if (exp_wait > 0) check("grant_latency", waited, exp_wait);
    check("owner", owner, it.core);
    check("issue_busy", busy, 1'b1);
    check("issue_we", mem_we, it.we);
    check("issue_addr", mem_addr, it.addr);
    check("issue_wdata", mem_wdata, it.wdata);
    if (!it.keep) core_req[it.core] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      if (k == it.cancel_at) core_req_reset[it.core] = 1'b1;
      check("wait_req", mem_req, 1'b1);
      check("wait_we", mem_we, it.we);
      check("wait_addr", mem_addr, it.addr);
      check("wait_wdata", mem_wdata, it.wdata);
      check("wait_no_ready", core_ready, '0);
    end
    mem_ready = 1'b1;
    mem_rdata = it.rdata;
    exp_ready = '0;
    if (it.cancel_at == 0) begin
      exp_ready[it.core] = 1'b1;
      exp_rdata  = it.rdata;
      last_rdata = it.rdata;
    end else begin
      exp_rdata = last_rdata;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = ~it.rdata;
    check("resp_ready", core_ready, exp_ready);
    check("resp_rdata", core_rdata, exp_rdata);
    check("resp_req_low", mem_req, 1'b0);
    check("resp_we_low", mem_we, 1'b0);
    core_req_reset[it.core] = 1'b0;
    @(negedge clk);
    check("hold_busy", busy, 1'b1);
    check("hold_ready", core_ready, '0);
    check("hold_rdata", core_rdata, exp_rdata);
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_req", mem_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    core_req = '0; core_we = '0; core_req_reset = '0;
    core_addr = '0; core_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    last_rdata = '0;
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single read from core1
    post(1, 1'b0, 20'h00040, '0, 128'hDEADBEEF_00000000_00000000_00000001, 1'b0, 0);
    serve(1, 4);

    // mem_ready while idle must be ignored
    mem_ready = 1'b1;
    mem_rdata = 128'h0BAD_0BAD;
    @(negedge clk);
    mem_ready = 1'b0;
    check("stray_ready", core_ready, '0);
    check("stray_rdata", core_rdata, last_rdata);
    check("stray_busy", busy, 1'b0);

    // Contention between core0 and core1 from reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_rdata = '0;
    post(0, 1'b0, 20'h00100, '0, 128'hA0A0, 1'b1, 0);
    post(1, 1'b0, 20'h00200, '0, 128'hB1B1, 1'b1, 0);
    post(0, 1'b0, 20'h00100, '0, 128'hA2A2, 1'b1, 0);
    post(1, 1'b0, 20'h00200, '0, 128'hB3B3, 1'b1, 0);
    for (int i = 0; i < 4; i++) serve(1, 3);
    core_req = '0;

    // Write from core0
    post(0, 1'b1, 20'h000FF, 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, 128'hC0FFEE, 1'b0, 0);
    serve(1, 5);

    // Asynchronous reset while waiting on the LLC
    drive_core(1, 1'b0, 20'h00333, '0);
    wait_issue(w);
    @(negedge clk);
    rst = 1'b0;
    #1 check_all_zero("arst");
    core_req = '0;
    @(negedge clk);
    rst = 1'b1;
    last_rdata = '0;

    // Core0 cancels two cycles after issue; core1 is pending behind it
    post(0, 1'b0, 20'h00444, '0, 128'h5555, 1'b0, 2);
    post(1, 1'b0, 20'h00555, '0, 128'h6666, 1'b0, 0);
    serve(1, 5);
    serve(1, 3);

    // Pointer wrap: core3 then core0 while core3 keeps requesting
    post(3, 1'b0, 20'h00777, '0, 128'h7777, 1'b1, 0);
    post(0, 1'b0, 20'h00888, '0, 128'h8888, 1'b0, 0);
    serve(1, 3);
    serve(1, 3);
    core_req = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
